fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the first instruction address after reset.
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port hold  in  1  decode stall; output registers frozen while high.
REQ-005 SHALL have port is_valid  out  1  pc/instruction hold a fetched instruction.
REQ-006 SHALL have port pc  out  32  address of the presented instruction.
REQ-007 SHALL have port instruction  out  32  presented instruction word.
REQ-008 SHALL have port is_pc_changing  in  1  combinational from decode: the presented instruction writes PC.
REQ-009 SHALL have port pc_write_valid  in  1  single-cycle pulse from write stage: new PC available.
REQ-010 SHALL have port pc_write_value  in  32  new PC, sampled when pc_write_valid is high.
REQ-011 SHALL have port mem_read  out  1  instruction memory request, held until accepted.
REQ-012 SHALL have port mem_address  out  32  request address, stable while mem_read is high.
REQ-013 SHALL have port mem_ready  in  1  request complete; mem_read_data valid this cycle.
REQ-014 SHALL have port mem_read_data  in  32  returned instruction word.

Function
REQ-015 SHALL use states FETCH (mem_read high), BLOCKED (buffer full, no request), REDIRECT (waiting for pc_write_valid).
REQ-016 SHALL allow at most one outstanding request; fetch_pc increments by 1 (word address) on each accepted mem_ready.
REQ-017 SHALL move mem_ready data to the output registers on the same edge if outputs are empty or consumed (!hold); otherwise SHALL store it in a one-entry skid buffer.
REQ-018 SHALL, when the buffer is occupied and outputs are consumed, move buffer to outputs and issue from FETCH again next cycle.
REQ-019 SHALL go FETCH->BLOCKED when the skid buffer is full; BLOCKED->FETCH when it drains.
REQ-020 SHALL, on is_pc_changing with is_valid and !hold, accept the current output, then clear is_valid, discard the buffer, drop mem_read, and enter REDIRECT.
REQ-021 SHALL discard the data of any request in flight at entry to REDIRECT; mem_read stays high until mem_ready completes that request.
REQ-022 SHALL, on pc_write_valid in any state, load fetch_pc from pc_write_value, clear is_valid and buffer, cancel in-flight data, and enter FETCH next cycle.
REQ-023 SHALL give pc_write_valid priority over is_pc_changing in the same cycle.
REQ-024 SHALL ignore is_pc_changing while is_valid is low.
REQ-025 SHALL keep pc/instruction unchanged while hold and is_valid are both high.
REQ-026 SHALL have minimum latency of 1 cycle from mem_ready to is_valid.

Reset
REQ-027 SHALL, while reset_n is low: is_valid=0, pc=0, instruction=0, mem_read=0, buffer empty, state=FETCH, fetch_pc=RESET_PC.
REQ-028 SHALL assert mem_read with mem_address=RESET_PC in the first cycle after reset_n rises.
REQ-029 SHALL, on reset mid-request, discard the request; the first mem_ready after release completes the new request.

Structure
REQ-030 SHALL take regval_t (32-bit), the fetch state enum, and the PC register index from the shared package.
REQ-031 SHALL implement the skid buffer as sub-module fetch_buffer (one entry: valid, pc, instruction).

Verification
REQ-032 Reset release, mem_ready one cycle after each request with words 0xA0,0xA1 -> mem_address 0,1; is_valid with pc=0 instr=0xA0, then pc=1 instr=0xA1.
REQ-033 hold high for 3 cycles during streaming -> outputs frozen, one buffered word, mem_read low in BLOCKED; after release, no word lost or duplicated.
REQ-034 is_pc_changing at pc=5 with request for 6 in flight -> word for 6 discarded, is_valid low, mem_read low until pc_write_valid with 0x40; next mem_address=0x40.
REQ-035 pc_write_valid=0x80 and is_pc_changing in the same cycle -> FETCH at 0x80; no REDIRECT entry.
REQ-036 reset_n pulsed low while waiting on mem_ready -> all outputs cleared; after release, mem_address=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose : register value type, fetch FSM state encoding, PC register index.
// Ports   : none (package).
package fetch_pkg;

   typedef logic [31:0] regval_t;

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_BLOCKED  = 2'd1,
      ST_REDIRECT = 2'd2
   } fetch_state_t;

   // Architectural register index that aliases the program counter.
   localparam int unsigned PC_REG_INDEX = 15;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry skid buffer holding a fetched pc/instruction pair
// Purpose : parks a returned word while the fetch output registers are stalled.
// Ports   : clock, reset_n         - clock, asynchronous active-low reset
//           load                   - capture load_pc/load_instruction, mark full
//           clear                  - drop the stored entry (drain or flush)
//           load_pc, load_instruction - entry to capture
//           is_full, buf_pc, buf_instruction - stored entry
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic    clock,
   input  logic    reset_n,
   input  logic    load,
   input  logic    clear,
   input  regval_t load_pc,
   input  regval_t load_instruction,
   output logic    is_full,
   output regval_t buf_pc,
   output regval_t buf_instruction
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         is_full         <= 1'b0;
         buf_pc          <= '0;
         buf_instruction <= '0;
      end else if (load) begin
         is_full         <= 1'b1;
         buf_pc          <= load_pc;
         buf_instruction <= load_instruction;
      end else if (clear) begin
         is_full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with one-entry skid buffer and PC redirect
// Purpose : issues one word-addressed instruction request at a time, presents the
//           returned word to decode, and handles stalls and PC redirects.
// Ports   : clock, reset_n                - clock, asynchronous active-low reset
//           hold                          - decode stall, output registers frozen
//           is_valid, pc, instruction     - presented instruction
//           is_pc_changing                - presented instruction writes PC
//           pc_write_valid, pc_write_value - new PC from write stage
//           mem_read, mem_address         - instruction memory request
//           mem_ready, mem_read_data      - request completion and returned word
module fetch
   import fetch_pkg::*;
#(
   parameter regval_t RESET_PC = 32'h0
) (
   input  logic    clock,
   input  logic    reset_n,
   input  logic    hold,
   output logic    is_valid,
   output regval_t pc,
   output regval_t instruction,
   input  logic    is_pc_changing,
   input  logic    pc_write_valid,
   input  regval_t pc_write_value,
   output logic    mem_read,
   output regval_t mem_address,
   input  logic    mem_ready,
   input  regval_t mem_read_data
);

   fetch_state_t state, next_state;
   regval_t      fetch_pc;
   regval_t      pend_addr;
   logic         pend, pend_next;
   logic         busy, take, out_free, redirect, flush;
   logic         out_from_buf, out_from_mem, out_drop, buf_load;
   logic         buf_full;
   regval_t      buf_pc, buf_instruction;

   // pend marks a request that was in flight when the stream was flushed: it
   // must still complete on the bus (address held stable) but its data is dropped.
   assign busy        = (state == ST_FETCH) || pend;
   assign mem_read    = reset_n && busy;
   assign mem_address = pend ? pend_addr : fetch_pc;
   assign take        = mem_ready && !pend && (state == ST_FETCH);
   assign out_free    = !is_valid || !hold;
   assign redirect    = is_valid && !hold && is_pc_changing;
   assign flush       = pc_write_valid || redirect;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      out_from_buf = 1'b0;
      out_from_mem = 1'b0;
      out_drop     = 1'b0;
      buf_load     = 1'b0;
      pend_next    = pend && !mem_ready;
      if (flush) begin
         pend_next  = busy && !mem_ready;
         next_state = pc_write_valid ? ST_FETCH : ST_REDIRECT;
      end else if (out_free) begin
         if (buf_full) begin
            // Only reachable from BLOCKED: drain, then resume requesting.
            out_from_buf = 1'b1;
            next_state   = ST_FETCH;
         end else if (take) begin
            out_from_mem = 1'b1;
         end else begin
            out_drop = 1'b1;
         end
      end else if (take) begin
         buf_load   = 1'b1;
         next_state = ST_BLOCKED;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         pend        <= 1'b0;
         pend_addr   <= '0;
         is_valid    <= 1'b0;
         pc          <= '0;
         instruction <= '0;
      end else begin
         pend <= pend_next;
         if (!pend) begin
            pend_addr <= fetch_pc;
         end
         if (pc_write_valid) begin
            fetch_pc <= pc_write_value;
         end else if (take && !flush) begin
            fetch_pc <= fetch_pc + 32'd1;
         end
         if (flush) begin
            is_valid <= 1'b0;
         end else if (out_from_buf) begin
            is_valid    <= 1'b1;
            pc          <= buf_pc;
            instruction <= buf_instruction;
         end else if (out_from_mem) begin
            is_valid    <= 1'b1;
            pc          <= fetch_pc;
            instruction <= mem_read_data;
         end else if (out_drop) begin
            is_valid <= 1'b0;
         end
      end
   end

   fetch_buffer u_buffer (
      .clock            (clock),
      .reset_n          (reset_n),
      .load             (buf_load),
      .clear            (flush || out_from_buf),
      .load_pc          (fetch_pc),
      .load_instruction (mem_read_data),
      .is_full          (buf_full),
      .buf_pc           (buf_pc),
      .buf_instruction  (buf_instruction)
   );

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for the fetch stage
module tb_fetch;

   localparam logic [31:0] RESET_PC_TB = 32'h0;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        hold = 1'b0;
   logic        is_valid;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic        is_pc_changing = 1'b0;
   logic        pc_write_valid = 1'b0;
   logic [31:0] pc_write_value = '0;
   logic        mem_read;
   logic [31:0] mem_address;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_read_data = '0;

   int checks = 0;
   int errors = 0;

   // Reference model: stream of presented words and memory bus state.
   logic [31:0] exp_pc;      // pc of the word that must be presented next
   int          held;        // fetched words not yet consumed (outputs + buffer)
   bit          wait_redir;  // redirect taken, no PC written yet
   bit          req_active;  // memory request outstanding
   bit          stale;       // outstanding request belongs to a flushed stream
   logic [31:0] req_addr;
   int          req_delay;
   bit          obs_valid;

   fetch #(.RESET_PC(RESET_PC_TB)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .hold           (hold),
      .is_valid       (is_valid),
      .pc             (pc),
      .instruction    (instruction),
      .is_pc_changing (is_pc_changing),
      .pc_write_valid (pc_write_valid),
      .pc_write_value (pc_write_value),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_ready      (mem_ready),
      .mem_read_data  (mem_read_data)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a < 32'h10) return 32'hA0 + a;
      return (a * 32'h9E3779B1) ^ 32'hC001D00D;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic observe(input int dly);
      @(negedge clock);
      obs_valid = is_valid;
      check_eq("is_valid", 32'(is_valid), 32'(held != 0));
      if (is_valid) begin
         check_eq("pc", pc, exp_pc);
         check_eq("instruction", instruction, memword(exp_pc));
      end
      check_eq("mem_read", 32'(mem_read), 32'(req_active || (!wait_redir && held < 2)));
      if (!mem_read) begin
         req_active = 1'b0;
         stale      = 1'b0;
      end else if (req_active) begin
         check_eq("mem_address_stable", mem_address, req_addr);
      end else begin
         check_eq("mem_address", mem_address, exp_pc + 32'(held));
         req_active = 1'b1;
         req_addr   = mem_address;
         req_delay  = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
      end
   endtask

   task automatic drive(input bit h, input bit ipc, input bit pcw, input logic [31:0] val);
      bit done;
      bit redir;
      done = req_active && (req_delay == 0);
      if (req_active && !done) req_delay--;
      mem_ready      = done;
      mem_read_data  = done ? memword(req_addr) : $urandom;
      hold           = h;
      is_pc_changing = ipc;
      pc_write_valid = pcw;
      pc_write_value = val;
      redir = obs_valid && !h && ipc;
      if (pcw || redir) begin
         stale      = req_active && !done;
         held       = 0;
         wait_redir = !pcw;
         if (pcw) exp_pc = val;
      end else begin
         if (obs_valid && !h) begin
            exp_pc++;
            held--;
         end
         if (done) begin
            if (stale) stale = 1'b0;
            else held++;
         end
      end
      if (done) req_active = 1'b0;
   endtask

   task automatic step(input int dly, input bit h, input bit ipc, input bit pcw, input logic [31:0] val);
      observe(dly);
      drive(h, ipc, pcw, val);
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      hold           = 1'b0;
      is_pc_changing = 1'b0;
      pc_write_valid = 1'b0;
      mem_ready      = 1'b0;
      #1;
      check_eq("rst_is_valid", 32'(is_valid), 32'd0);
      check_eq("rst_pc", pc, 32'd0);
      check_eq("rst_instruction", instruction, 32'd0);
      check_eq("rst_mem_read", 32'(mem_read), 32'd0);
      repeat (2) @(negedge clock);
      reset_n    = 1'b1;
      exp_pc     = RESET_PC_TB;
      held       = 0;
      wait_redir = 1'b0;
      req_active = 1'b0;
      stale      = 1'b0;
      obs_valid  = 1'b0;
      #1;
      check_eq("post_rst_mem_read", 32'(mem_read), 32'd1);
      check_eq("post_rst_mem_address", mem_address, RESET_PC_TB);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      bit found;
      do_reset();

      // Streaming from reset, memory answers every request immediately.
      repeat (5) step(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Decode stall for 3 cycles while streaming, then release.
      repeat (3) step(0, 1'b1, 1'b0, 1'b0, 32'd0);
      repeat (5) step(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Redirect at pc=5 with the request for 6 in flight.
      step(1, 1'b0, 1'b0, 1'b1, 32'd3);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         observe(2);
         found = obs_valid && (pc == 32'd5);
         drive(1'b0, found, 1'b0, $urandom);
      end
      check_eq("reach_pc5", 32'(found), 32'd1);
      repeat (6) step(-1, 1'b0, 1'b0, 1'b0, $urandom);
      step(0, 1'b0, 1'b0, 1'b1, 32'h40);
      repeat (4) step(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // PC write and redirect in the same cycle: the write wins.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         observe(0);
         found = obs_valid;
         drive(1'b0, found, found, 32'h80);
      end
      check_eq("pcw_priority_seen", 32'(found), 32'd1);
      repeat (4) step(0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Reset while a request is waiting on mem_ready.
      observe(2);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      do_reset();
      repeat (4) step(-1, 1'b0, 1'b0, 1'b0, 32'd0);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         bit h, c, w;
         h = ($urandom_range(0, 99) < 30);
         c = ($urandom_range(0, 99) < 12);
         w = wait_redir ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 3);
         step(-1, h, c, w, $urandom_range(0, 511));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
